// File: rtl/collision_pkg.sv
// Shared definitions for the object collision detector.
// Contents: the number of collision types, the bit index of each type in the
// collision vectors, the vector type itself and the per-type frame state.
package collision_pkg;

    localparam int unsigned NUM_HITS = 5;

    localparam int unsigned HIT_BIRD_PIG    = 0;
    localparam int unsigned HIT_BIRD_WOOD   = 1;
    localparam int unsigned HIT_BIRD_BOX    = 2;
    localparam int unsigned HIT_BIRD_BORDER = 3;
    localparam int unsigned HIT_PIG_WOOD    = 4;

    typedef logic [NUM_HITS-1:0] hit_vec_t;

    // Per-type frame state: has this coincidence occurred yet in the frame.
    typedef enum logic {
        SeenIdle,
        SeenHit
    } seen_state_e;

endpackage

// File: rtl/hit_latch.sv
// Per-collision-type frame tracker.
// Remembers whether its coincidence has occurred in the current frame, emits
// a one-cycle pulse on the first occurrence per frame, and captures the
// finished frame's flag on every start-of-frame strobe.
// Ports:
//   clk, resetN   pixel clock, asynchronous active-low reset
//   startOfFrame  first pixel of a new frame; this cycle belongs to the new frame
//   hit           coincidence for this type in the current cycle
//   pulse         registered one-cycle pulse for the first hit of a frame
//   pulseNext     value pulse will take at the next edge (for same-edge counting)
//   frameSeen     registered: type occurred in the previous complete frame
module hit_latch
    import collision_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit,
    output logic pulse,
    output logic pulseNext,
    output logic frameSeen
);

    seen_state_e state_q;
    logic        pulse_q;
    logic        frame_seen_q;

    // The strobe cycle opens a fresh frame, so the old seen state does not mask it.
    assign pulseNext = hit & (startOfFrame | (state_q == SeenIdle));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= SeenIdle;
            pulse_q      <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            pulse_q <= pulseNext;
            if (startOfFrame) begin
                // Capture the closing frame before the strobe cycle's own hit.
                frame_seen_q <= (state_q == SeenHit);
                state_q      <= hit ? SeenHit : SeenIdle;
            end else if (hit) begin
                state_q <= SeenHit;
            end
        end
    end

    assign pulse     = pulse_q;
    assign frameSeen = frame_seen_q;

endmodule

// File: rtl/object_collision_detector.sv
// Object collision detector.
// Watches the painters' per-pixel drawing requests, pulses once per frame for
// the first overlap of each collision type, latches a per-frame summary on
// each start-of-frame strobe and counts frames with a bird-pig hit.
// Ports:
//   clk, resetN            pixel clock, asynchronous active-low reset
//   startOfFrame           one-cycle strobe on the first pixel of a frame
//   *DrawingRequest        painter requests for the current pixel
//   clearScore             synchronous clear of pigHitCount (wins over increment)
//   collisionPulse[4:0]    one-cycle first-overlap pulse per type
//   frameCollisions[4:0]   types seen in the previous complete frame
//   pigHitCount            saturating count of bird-pig pulses
module object_collision_detector
    import collision_pkg::*;
#(
    parameter int unsigned PIG_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 birdDrawingRequest,
    input  logic                 pigDrawingRequest,
    input  logic                 woodDrawingRequest,
    input  logic                 boxDrawingRequest,
    input  logic                 borderDrawingRequest,
    input  logic                 clearScore,
    output logic [4:0]           collisionPulse,
    output logic [4:0]           frameCollisions,
    output logic [PIG_CNT_W-1:0] pigHitCount
);

    localparam logic [PIG_CNT_W-1:0] CntMax = {PIG_CNT_W{1'b1}};

    hit_vec_t                 coinc;
    hit_vec_t                 pulse_next;
    hit_vec_t                 pulse_q;
    hit_vec_t                 frame_seen;
    logic     [PIG_CNT_W-1:0] cnt_d;
    logic     [PIG_CNT_W-1:0] cnt_q;

    always_comb begin
        coinc                  = '0;
        coinc[HIT_BIRD_PIG]    = birdDrawingRequest & pigDrawingRequest;
        coinc[HIT_BIRD_WOOD]   = birdDrawingRequest & woodDrawingRequest;
        coinc[HIT_BIRD_BOX]    = birdDrawingRequest & boxDrawingRequest;
        coinc[HIT_BIRD_BORDER] = birdDrawingRequest & borderDrawingRequest;
        coinc[HIT_PIG_WOOD]    = pigDrawingRequest & woodDrawingRequest;
    end

    for (genvar g = 0; g < NUM_HITS; g++) begin : g_hit
        hit_latch u_hit_latch (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .hit          (coinc[g]),
            .pulse        (pulse_q[g]),
            .pulseNext    (pulse_next[g]),
            .frameSeen    (frame_seen[g])
        );
    end

    // Count on the same edge that registers the bird-pig pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (clearScore) begin
            cnt_d = '0;
        end else if (pulse_next[HIT_BIRD_PIG] && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + PIG_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign collisionPulse  = pulse_q;
    assign frameCollisions = frame_seen;
    assign pigHitCount     = cnt_q;

endmodule

// File: doc/object_collision_detector.md
# object_collision_detector

- Observes the per-pixel drawing requests that object painters send to the priority mux, and reports object overlaps.
- Emits a one-cycle pulse for the first overlap of each collision type in a frame.
- Latches a per-frame collision summary at each frame boundary and keeps a saturating pig-hit counter.
- Sits beside the RGB mux, fed by the same painter outputs and the VGA controller's start-of-frame strobe; its outputs drive game-control logic.

## Interface
- `PIG_CNT_W`, 4: width of the pig-hit counter; the counter saturates at 2^PIG_CNT_W−1.
- `clk`  in  1  pixel clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle strobe from the VGA controller marking the first pixel of a frame.
- `birdDrawingRequest`  in  1  bird (smiley) painter is drawing this pixel.
- `pigDrawingRequest`  in  1  pig painter is drawing this pixel.
- `woodDrawingRequest`  in  1  wood painter is drawing this pixel.
- `boxDrawingRequest`  in  1  box painter is drawing this pixel.
- `borderDrawingRequest`  in  1  screen border / background frame pixel.
- `clearScore`  in  1  synchronous clear of `pigHitCount`.
- `collisionPulse`  out  5  one-cycle pulse per collision type; bit indices come from the package.
- `frameCollisions`  out  5  types seen in the previous complete frame.
- `pigHitCount`  out  PIG_CNT_W  number of frames with a bird–pig hit, saturating.

## Operation
- Coincidence vector, evaluated combinationally every cycle:
  - `BIRD_PIG` = bird & pig
  - `BIRD_WOOD` = bird & wood
  - `BIRD_BOX` = bird & box
  - `BIRD_BORDER` = bird & border
  - `PIG_WOOD` = pig & wood
- Each type has a `seen` flag holding the frame state. Per type, per cycle:
  - `startOfFrame` high: `seen` ← coincidence. The cycle belongs to the new frame.
  - Otherwise: `seen` ← `seen` | coincidence.
- `collisionPulse[i]` is registered high for exactly one cycle when coincidence[i] is high and the type is not yet marked in this frame.
  - "Not yet marked" means `seen[i]`=0, or `startOfFrame`=1.
  - At most one pulse per type per frame, regardless of how many pixels overlap.
- On `startOfFrame`, `frameCollisions` ← `seen`. This captures the old frame and excludes the strobe cycle's coincidence.
- `pigHitCount` increments on the cycle its `BIRD_PIG` pulse is registered; it saturates at the maximum and never wraps.
  - `clearScore` sets it to 0.
  - If `clearScore` and an increment coincide, the result is 0.
- Several types may pulse in the same cycle; all are independent.
- The block has no frame-counting state machine. The per-type `seen` flag is a two-state FSM: IDLE (not seen) → HIT on coincidence; any state → IDLE or HIT on `startOfFrame`, per the rule above.

## Timing
- Reset (asynchronous, `resetN`=0) clears `seen`, `collisionPulse`, `frameCollisions` and `pigHitCount` to 0 immediately.
- Reset mid-frame discards partial-frame state. The first `frameCollisions` update after reset reflects only the cycles since reset.
- Latency:
  - Pixel coincidence at cycle N → `collisionPulse` high during cycle N+1.
  - `pigHitCount` updated at N+1, same edge as the pulse.
  - `startOfFrame` at cycle N → `frameCollisions` valid from N+1 until the next strobe.
- Inputs are assumed synchronous to `clk`, with no internal resynchronisation. Painter outputs are registered upstream.
- Back-to-back `startOfFrame` pulses are legal: each one closes a one-cycle frame.

## Structure
- Package `collision_pkg` holds:
  - `NUM_HITS`=5.
  - Index localparams `HIT_BIRD_PIG`=0, `HIT_BIRD_WOOD`=1, `HIT_BIRD_BOX`=2, `HIT_BIRD_BORDER`=3, `HIT_PIG_WOOD`=4.
  - `typedef logic [NUM_HITS-1:0] hit_vec_t`.
- Sub-module `hit_latch` provides one instance per type, generated over `NUM_HITS`.
  - Inputs: `clk`, `resetN`, `startOfFrame`, `hit`.
  - Outputs: `pulse`, `frameSeen`.
- Top level: coincidence logic, the generate loop and the saturating counter.

## Test plan
- Bird & pig both high for 10 consecutive cycles mid-frame → `collisionPulse`=5'b00001 for one cycle only, 1 cycle after the first overlap. `pigHitCount` 0→1. On the next `startOfFrame`, `frameCollisions`=5'b00001.
- Bird&wood and pig&wood overlap on the same cycle → `collisionPulse`=5'b10010 for one cycle. Next frame's summary = 5'b10010.
- Bird & border overlap in the same cycle as `startOfFrame` → `frameCollisions` excludes bit 3, a pulse on bit 3 is issued, and the following frame's summary includes bit 3.
- Bird–pig hits in 20 consecutive frames with `PIG_CNT_W`=4 → `pigHitCount` stops at 15. Then `clearScore` together with a hit → 0.
- `resetN` pulled low mid-frame after a bird–box hit → all outputs 0 asynchronously. After release, with no hits, the next strobe gives `frameCollisions`=0.
- No overlaps for 3 frames → no pulses, `frameCollisions`=0, count unchanged.
